// File: rtl/fpu_wb_buffer.sv
// In-order result/exception buffer between the FPU sign-injection/compare units
// and the FP register-file writeback port, with a sticky invalid-operation flag.
module fpu_wb_buffer #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_rd,
  input  logic [31:0]   in_data,
  input  logic          in_exc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_rd,
  output logic [31:0]   out_data,
  output logic          out_exc,
  input  logic          flag_clr,
  output logic          flag_nv,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } entry_t;

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  entry_t        head;
  logic          push;
  logic          pop;

  // Readiness comes from registered occupancy only, so a full buffer refuses
  // a push even when the head is being consumed in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head     = out_valid ? mem[rp] : '0;
  assign out_rd   = head.rd;
  assign out_data = head.data;
  assign out_exc  = head.exc;

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= entry_t'{rd: in_rd, data: in_data, exc: in_exc};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

  // Setting from a committed exc=1 entry wins over a same-edge software clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_nv <= 1'b0;
    end else if (pop && head.exc) begin
      flag_nv <= 1'b1;
    end else if (flag_clr) begin
      flag_nv <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Bench for fpu_wb_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fpu_wb_buffer;

  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_data = '0;
  logic          in_exc = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4:0]    out_rd;
  logic [31:0]   out_data;
  logic          out_exc;
  logic          flag_clr = 1'b0;
  logic          flag_nv;
  logic [AW:0]   count;

  int total = 0;
  int bad = 0;

  fpu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_exc(out_exc),
    .flag_clr(flag_clr), .flag_nv(flag_nv), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending results and a sticky bit.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } item_t;

  item_t m_q[$];
  logic  m_nv;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
      m_nv = 1'b0;
    end else begin
      bit   acc;
      bit   take;
      item_t it;
      acc  = in_valid && (m_q.size() < DEPTH);
      take = out_ready && (m_q.size() > 0);
      if (take) begin
        it = m_q.pop_front();
        if (it.exc) m_nv = 1'b1;
        else if (flag_clr) m_nv = 1'b0;
      end else if (flag_clr) begin
        m_nv = 1'b0;
      end
      if (acc) m_q.push_back('{rd: in_rd, data: in_data, exc: in_exc});
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("m_in_ready",  in_ready,  m_q.size() < DEPTH);
      check("m_out_valid", out_valid, m_q.size() > 0);
      check("m_count",     count,     m_q.size());
      check("m_flag_nv",   flag_nv,   m_nv);
      check("m_out_rd",    out_rd,    m_q.size() > 0 ? m_q[0].rd : 5'd0);
      check("m_out_data",  out_data,  m_q.size() > 0 ? m_q[0].data : 32'd0);
      check("m_out_exc",   out_exc,   m_q.size() > 0 ? m_q[0].exc : 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic e);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    in_exc   = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rstn = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);

    // Single push / pop.
    drive_in(1, 5'd3, 32'h3F80_0000, 0);
    check("single_push_cycle_valid", out_valid, 0);
    step();
    drive_in(0, 0, 0, 0);
    check("single_valid", out_valid, 1);
    check("single_rd", out_rd, 3);
    check("single_data", out_data, 32'h3F80_0000);
    out_ready = 1;
    step();
    out_ready = 0;
    check("single_count", count, 0);
    check("single_nv", flag_nv, 0);

    // Fill to full, refuse a fifth, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive_in(1, 5'(i), 32'(i), 0);
      step();
    end
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    drive_in(1, 5'd5, 32'd5, 0);
    step();
    drive_in(0, 0, 0, 0);
    check("fifth_refused_count", count, 4);
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", out_data, 32'(k));
      step();
      if (k == 1) check("ready_after_first_pop", in_ready, 1);
    end
    out_ready = 0;
    check("drained_valid", out_valid, 0);

    // Streaming with one entry in flight; pointers wrap several times.
    drive_in(1, 5'd0, 32'd0, 0);
    step();
    out_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      drive_in(1, 5'(i), 32'(i), 0);
      check("stream_head", out_data, 32'(i - 1));
      check("stream_count", count, 1);
      step();
    end
    drive_in(0, 0, 0, 0);
    check("stream_last", out_data, 32'd20);
    step();
    out_ready = 0;
    check("stream_empty", count, 0);

    // Sticky NV flag: set by a committed exc entry, survives exc=0 pops.
    drive_in(1, 5'd7, 32'h7FC0_0000, 1);
    step();
    drive_in(0, 0, 0, 0);
    check("nan_exc_head", out_exc, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    check("nv_set", flag_nv, 1);
    drive_in(1, 5'd8, 32'd1, 0);
    step();
    drive_in(0, 0, 0, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    check("nv_sticky", flag_nv, 1);
    flag_clr = 1;
    step();
    flag_clr = 0;
    check("nv_cleared", flag_nv, 0);

    // Clear on the same edge as an exc=1 pop: set wins.
    drive_in(1, 5'd9, 32'h7FC0_0001, 1);
    step();
    drive_in(0, 0, 0, 0);
    out_ready = 1;
    flag_clr  = 1;
    step();
    out_ready = 0;
    flag_clr  = 0;
    check("set_wins", flag_nv, 1);

    // Queue three entries, then reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      drive_in(1, 5'(10 + i), 32'hA0 + 32'(i), 0);
      step();
    end
    drive_in(0, 0, 0, 0);
    check("pre_reset_count", count, 3);
    #2 rstn = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_count", count, 0);
    check("async_nv", flag_nv, 0);
    #4 rstn = 1'b1;
    step();
    drive_in(1, 5'd9, 32'h0000_00AB, 0);
    step();
    drive_in(0, 0, 0, 0);
    check("post_reset_rd", out_rd, 9);
    check("post_reset_data", out_data, 32'h0000_00AB);
    check("post_reset_count", count, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    check("post_reset_empty", count, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_wb_buffer.md
# fpu_wb_buffer

Result/exception buffer between the FPU sign-injection and compare units and the floating-point register-file writeback port. Accepts one completed FPU result per cycle with its destination register and NaN-input exception flag, queues up to DEPTH entries in order, and presents them to writeback under a valid/ready handshake. Keeps a sticky invalid-operation flag (fcsr NV) that is set by committed results and cleared by software.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- Derived: AW = $clog2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a result this cycle
- in_ready  out  1  buffer can accept (= not full)
- in_rd  in  5  destination f-register index
- in_data  in  32  IEEE-754 single result
- in_exc  in  1  invalid-operation flag from the FPU unit (NaN input)
- out_valid  out  1  head entry present (= not empty)
- out_ready  in  1  writeback consumes head this cycle
- out_rd  out  5  head destination index
- out_data  out  32  head result
- out_exc  out  1  head exception flag
- flag_clr  in  1  clear sticky NV flag
- flag_nv  out  1  sticky invalid-operation flag
- count  out  AW+1  number of occupied entries, 0..DEPTH

## Operation

- Storage: DEPTH × {rd[4:0], data[31:0], exc}, register array; write pointer wp and read pointer rp, AW bits each, wrap modulo DEPTH; occupancy counter count.
- Push: in_valid && in_ready at a rising edge → write entry at wp, wp ← wp+1.
- Pop: out_valid && out_ready at a rising edge → rp ← rp+1.
- count ← count + push − pop; simultaneous push and pop leaves count unchanged.
- in_ready = (count != DEPTH); depends on registered state only, never on out_ready. Full buffer with out_ready=1 still refuses the push that cycle.
- out_valid = (count != 0). out_rd/out_data/out_exc = entry at rp when out_valid, else all zero.
- Order strictly FIFO; no entry dropped, duplicated or reordered.
- Sticky flag: on a pop whose entry has exc=1, flag_nv ← 1. flag_clr=1 at an edge → flag_nv ← 0, unless a pop with exc=1 occurs at the same edge, in which case flag_nv ← 1 (set wins).
- Producer must hold in_* stable while in_valid && !in_ready; buffer does not check.
- Asserting out_ready with out_valid=0 has no effect.

## Timing

- Reset (rstn low, asynchronous): wp=rp=0, count=0, flag_nv=0 → in_ready=1, out_valid=0, out_* = 0. Storage contents need not reset.
- Reset mid-operation discards all queued entries and the sticky flag immediately, without waiting for a clock edge.
- Latency: entry pushed at edge N is visible on out_* with out_valid=1 after edge N (cycle N+1); no combinational fall-through from in_* to out_*.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full (count=DEPTH): in_ready=0; pop at edge N makes in_ready=1 in cycle N+1.
- Empty: out_valid=0; a push at edge N raises out_valid in cycle N+1.
- flag_nv updates in the cycle after the committing pop edge.

## Test plan

- Reset then single push {rd=3, data=0x3F800000, exc=0}: out_valid=0 in the push cycle, 1 the next cycle with the same fields; pop → count=0, flag_nv=0.
- Fill with DEPTH=4 entries, out_ready=0: in_ready=0 after the 4th push, count=4; a 5th in_valid is not accepted; drain with out_ready=1 → data order 1,2,3,4, in_ready=1 one cycle after the first pop.
- Continuous streaming, in_valid=out_ready=1 for 20 cycles with data=cycle index: count stays at 1, every value seen exactly once in order, pointers wrap correctly.
- Push {data=0x7FC00000, exc=1} then pop: flag_nv=1 the cycle after the pop, remains 1 through later exc=0 pops; flag_clr pulse → 0.
- flag_clr asserted on the same edge as a pop with exc=1: flag_nv=1 afterwards.
- Three entries queued, rstn pulled low between clock edges: out_valid=0, in_ready=1, count=0, flag_nv=0 immediately; after release, the next push/pop sequence behaves as after a fresh reset.
